// File: rtl/ga_cmd_queue_if.sv
// ga_cmd_queue_if: instruction-side and issue-side signals of the GA command queue.
//   slave  modport : the queue itself (accepts instructions, presents the head entry)
//   master modport : the environment (Ibex ID stage + GA coprocessor)
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// the offering side holds its payload while valid is high and ready is low.
interface ga_cmd_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    // Instruction side (Ibex decoder / operand read)
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            illegal_o;

    // Issue side (GA coprocessor)
    logic            issue_valid_o;
    logic            issue_ready_i;
    logic [2:0]      issue_op_sel_o;
    logic [2:0]      issue_funct3_o;
    logic [6:0]      issue_funct7_o;
    logic [4:0]      issue_rd_o;
    logic [XLEN-1:0] issue_rs1_data_o;
    logic [XLEN-1:0] issue_rs2_data_o;

    // Status
    logic            ga_enabled_o;
    logic [CW-1:0]   queue_count_o;
    logic            draining_o;

    modport slave (
        input  instr_valid_i, instr_i, rs1_data_i, rs2_data_i, issue_ready_i,
        output instr_ready_o, illegal_o, issue_valid_o, issue_op_sel_o, issue_funct3_o,
               issue_funct7_o, issue_rd_o, issue_rs1_data_o, issue_rs2_data_o,
               ga_enabled_o, queue_count_o, draining_o
    );

    modport master (
        output instr_valid_i, instr_i, rs1_data_i, rs2_data_i, issue_ready_i,
        input  instr_ready_o, illegal_o, issue_valid_o, issue_op_sel_o, issue_funct3_o,
               issue_funct7_o, issue_rd_o, issue_rs1_data_o, issue_rs2_data_o,
               ga_enabled_o, queue_count_o, draining_o
    );
endinterface

// File: rtl/ga_cmd_queue.sv
// ga_cmd_queue: decodes GA custom-opcode instructions, buffers issuable commands with
// their operands in a DEPTH-entry FIFO toward the GA coprocessor, and executes the GA
// control ops (RESET, ENABLE, DISABLE, FLUSH) locally.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : ga_cmd_queue_if.slave -- instruction handshake + operands, illegal pulse,
//             head-entry issue handshake, enable / count / draining status.
//             draining_o doubles as the FSM state (high in ST_DRAIN).
module ga_cmd_queue #(
    parameter int   DEPTH       = 4,
    parameter int   XLEN        = 32,
    parameter logic EN_AT_RESET = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    ga_cmd_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_NONE      = 3'd0,
        OP_ARITH     = 3'd1,
        OP_LOAD_REG  = 3'd2,
        OP_STORE_REG = 3'd3,
        OP_LOAD_MEM  = 3'd4,
        OP_STORE_MEM = 3'd5,
        OP_STATUS    = 3'd6,
        OP_CONFIG    = 3'd7
    } op_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0]      op_sel;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } entry_t;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    assign opcode = bus.instr_i[6:0];
    assign funct3 = bus.instr_i[14:12];

    // rs1/rs2 index fields are resolved by the operand read stage upstream.
    logic unused_rs_fields;
    assign unused_rs_fields = ^bus.instr_i[24:15];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    op_sel_e dec_op;
    logic    dec_enq;
    logic    dec_illegal;
    logic    dec_reset;
    logic    dec_enable;
    logic    dec_disable;
    logic    dec_flush;

    always_comb begin
        dec_op      = OP_NONE;
        dec_enq     = 1'b0;
        dec_illegal = 1'b0;
        dec_reset   = 1'b0;
        dec_enable  = 1'b0;
        dec_disable = 1'b0;
        dec_flush   = 1'b0;
        unique case (opcode)
            7'h0B: begin
                dec_op  = OP_ARITH;
                dec_enq = 1'b1;
            end
            7'h2B: begin
                if (funct3 == 3'b000) begin
                    dec_op  = OP_LOAD_REG;
                    dec_enq = 1'b1;
                end else if (funct3 <= 3'b101) begin
                    dec_op  = OP_STORE_REG;
                    dec_enq = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'h5B: begin
                if (funct3 > 3'b101) begin
                    dec_illegal = 1'b1;
                end else begin
                    // even funct3 loads, odd funct3 stores
                    dec_op  = funct3[0] ? OP_STORE_MEM : OP_LOAD_MEM;
                    dec_enq = 1'b1;
                end
            end
            7'h7B: begin
                unique case (funct3)
                    3'b000:  begin dec_op = OP_CONFIG; dec_enq = 1'b1; end
                    3'b001:  begin dec_op = OP_STATUS; dec_enq = 1'b1; end
                    3'b010:  dec_reset   = 1'b1;
                    3'b011:  dec_enable  = 1'b1;
                    3'b100:  dec_disable = 1'b1;
                    3'b101:  dec_flush   = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase

        // Data-path ops need the GA enabled; CONFIG/STATUS and local ops do not.
        if (dec_enq && !bus.ga_enabled_o &&
            (dec_op != OP_CONFIG) && (dec_op != OP_STATUS)) begin
            dec_enq     = 1'b0;
            dec_op      = OP_NONE;
            dec_illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          enabled_q;
    logic          illegal_q;
    state_e        state_q;
    state_e        state_d;
    logic          enabled_d;

    logic accept;
    logic enq_fire;
    logic pop_fire;
    logic clear;

    assign bus.instr_ready_o = (state_q == ST_RUN) && (count_q < CW'(DEPTH));
    assign accept   = bus.instr_valid_i && bus.instr_ready_o;
    assign enq_fire = accept && dec_enq;
    assign pop_fire = bus.issue_valid_o && bus.issue_ready_i;
    // The head may still be popped on the clearing edge; it counts as issued.
    assign clear    = accept && (dec_flush || dec_reset);

    entry_t new_entry;
    assign new_entry = '{
        op_sel: dec_op,
        funct3: funct3,
        funct7: bus.instr_i[31:25],
        rd:     bus.instr_i[11:7],
        rs1:    bus.rs1_data_i,
        rs2:    bus.rs2_data_i
    };

    // Storage is not reset; validity is carried entirely by count_q.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_fire) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(enq_fire) - CW'(pop_fire);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && dec_illegal;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            enabled_q <= EN_AT_RESET;
        end else begin
            state_q   <= state_d;
            enabled_q <= enabled_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        enabled_d = enabled_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept && dec_reset)   enabled_d = EN_AT_RESET;
                if (accept && dec_enable)  enabled_d = 1'b1;
                if (accept && dec_disable) state_d   = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Instructions are blocked here, so the queue can only shrink.
                if (count_q == '0) begin
                    enabled_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    entry_t head;
    assign bus.issue_valid_o = (count_q != '0);
    assign head = bus.issue_valid_o ? mem[rd_ptr_q] : '0;

    assign bus.issue_op_sel_o   = head.op_sel;
    assign bus.issue_funct3_o   = head.funct3;
    assign bus.issue_funct7_o   = head.funct7;
    assign bus.issue_rd_o       = head.rd;
    assign bus.issue_rs1_data_o = head.rs1;
    assign bus.issue_rs2_data_o = head.rs2;

    assign bus.illegal_o     = illegal_q;
    assign bus.ga_enabled_o  = enabled_q;
    assign bus.queue_count_o = count_q;
    assign bus.draining_o    = (state_q == ST_DRAIN);
endmodule

// File: tb/tb_ga_cmd_queue.sv
// tb_ga_cmd_queue: directed + randomized bench for ga_cmd_queue against a
// queue-based reference model of the command queue's rules.
module tb_ga_cmd_queue;
    localparam int   DEPTH = 4;
    localparam int   XLEN  = 32;
    localparam logic EN_RST = 1'b0;
    localparam int   EW = 3 + 3 + 7 + 5 + 2 * XLEN;

    localparam int K_ILL = 0, K_ENQ = 1, K_RST = 2, K_EN = 3, K_DIS = 4, K_FLUSH = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    ga_cmd_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    ga_cmd_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .EN_AT_RESET(EN_RST)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // ---------------- scoreboard / model state ----------------
    logic [EW-1:0] exp_q[$];
    logic          m_en;
    logic          m_drain;
    logic          m_ill;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] opc);
        logic [31:0] r;
        r = {f7, 5'd0, 5'd0, f3, rd, opc};
        return r;
    endfunction

    // Classification straight from the opcode/funct3 table.
    function automatic int classify(input logic [31:0] ins, input logic en, output logic [2:0] op);
        logic [6:0] opc;
        logic [2:0] f3;
        int         k;
        opc = ins[6:0];
        f3  = ins[14:12];
        op  = 3'd0;
        k   = K_ILL;
        if (opc == 7'h0B) begin
            op = 3'd1; k = K_ENQ;
        end else if (opc == 7'h2B) begin
            if (f3 == 3'd0)      begin op = 3'd2; k = K_ENQ; end
            else if (f3 <= 3'd5) begin op = 3'd3; k = K_ENQ; end
        end else if (opc == 7'h5B) begin
            if (f3 <= 3'd5) begin op = (f3 % 2 == 0) ? 3'd4 : 3'd5; k = K_ENQ; end
        end else if (opc == 7'h7B) begin
            case (f3)
                3'd0: begin op = 3'd7; k = K_ENQ; end
                3'd1: begin op = 3'd6; k = K_ENQ; end
                3'd2: k = K_RST;
                3'd3: k = K_EN;
                3'd4: k = K_DIS;
                3'd5: k = K_FLUSH;
                default: k = K_ILL;
            endcase
        end
        if (k == K_ENQ && op >= 3'd1 && op <= 3'd5 && !en) begin
            k  = K_ILL;
            op = 3'd0;
        end
        return k;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_en    = EN_RST;
        m_drain = 1'b0;
        m_ill   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int         sz;
        logic       rdy;
        logic       acc;
        logic       drain_done;
        logic [2:0] op;
        int         k;
        sz  = exp_q.size();
        rdy = !m_drain && (sz < DEPTH);
        acc = bus.instr_valid_i && rdy;
        drain_done = m_drain && (sz == 0);
        k = classify(bus.instr_i, m_en, op);
        if (sz > 0 && bus.issue_ready_i) void'(exp_q.pop_front());
        m_ill = acc && (k == K_ILL);
        if (acc) begin
            case (k)
                K_ENQ:   exp_q.push_back({op, bus.instr_i[14:12], bus.instr_i[31:25],
                                          bus.instr_i[11:7], bus.rs1_data_i, bus.rs2_data_i});
                K_RST:   begin exp_q.delete(); m_en = EN_RST; end
                K_EN:    m_en = 1'b1;
                K_DIS:   m_drain = 1'b1;
                K_FLUSH: exp_q.delete();
                default: ;
            endcase
        end
        if (drain_done) begin
            m_drain = 1'b0;
            m_en    = 1'b0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input string fld, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [EW-1:0] h;
        int            sz;
        sz = exp_q.size();
        h  = (sz > 0) ? exp_q[0] : '0;
        chk(tag, "issue_valid", 64'(bus.issue_valid_o), 64'(sz > 0));
        chk(tag, "op_sel",      64'(bus.issue_op_sel_o), 64'(h[EW-1 -: 3]));
        chk(tag, "funct3",      64'(bus.issue_funct3_o), 64'(h[EW-4 -: 3]));
        chk(tag, "funct7",      64'(bus.issue_funct7_o), 64'(h[EW-7 -: 7]));
        chk(tag, "rd",          64'(bus.issue_rd_o),     64'(h[EW-14 -: 5]));
        chk(tag, "rs1",         64'(bus.issue_rs1_data_o), 64'(h[2*XLEN-1 -: XLEN]));
        chk(tag, "rs2",         64'(bus.issue_rs2_data_o), 64'(h[XLEN-1:0]));
        chk(tag, "count",       64'(bus.queue_count_o), 64'(sz));
        chk(tag, "instr_ready", 64'(bus.instr_ready_o), 64'(!m_drain && sz < DEPTH));
        chk(tag, "illegal",     64'(bus.illegal_o), 64'(m_ill));
        chk(tag, "enabled",     64'(bus.ga_enabled_o), 64'(m_en));
        chk(tag, "draining",    64'(bus.draining_o), 64'(m_drain));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic ir);
        bus.instr_valid_i = v;
        bus.instr_i       = ins;
        bus.rs1_data_i    = a;
        bus.rs2_data_i    = b;
        bus.issue_ready_i = ir;
    endtask

    // Called at a falling edge: model the coming rising edge, then check at the next falling edge.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input int n, input logic ir, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 32'h0, '0, '0, ir);
            cycle(tag);
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst_ni = 1'b0;
        model_reset();
        #1 check_all(tag);
        @(posedge clk);
        #2 rst_ni = 1'b1;
        drive(1'b0, 32'h0, '0, '0, 1'b0);
        @(negedge clk);
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        int         r;
        logic [6:0] opc;
        r = $urandom_range(0, 9);
        if (r <= 2)      opc = 7'h0B;
        else if (r == 3) opc = 7'h2B;
        else if (r <= 5) opc = 7'h5B;
        else if (r <= 8) opc = 7'h7B;
        else             opc = 7'h33;
        return mk(7'($urandom), 3'($urandom), 5'($urandom), opc);
    endfunction

    localparam logic [31:0] I_ENABLE  = 32'h0000_307B;
    localparam logic [31:0] I_DISABLE = 32'h0000_407B;
    localparam logic [31:0] I_FLUSH   = 32'h0000_507B;

    // ---------------- stimulus ----------------
    initial begin
        rst_ni = 1'b0;
        drive(1'b0, 32'h0, '0, '0, 1'b0);
        model_reset();
        #3 check_all("reset");
        @(posedge clk);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        check_all("reset_rel");

        // Enable then a single ARITH (funct3 010, rd 5)
        drive(1'b1, I_ENABLE, '0, '0, 1'b1);              cycle("enable");
        drive(1'b1, mk(7'h15, 3'b010, 5'd5, 7'h0B), 32'h11, 32'h22, 1'b1);
        cycle("arith");
        idle(2, 1'b1, "arith_pop");

        // Fill with LOAD_MEM under backpressure, then free one slot
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(7'(i), 3'(2 * (i % 3)), 5'(i + 1), 7'h5B), 32'(i + 100), 32'(i + 200), 1'b0);
            cycle("fill");
        end
        drive(1'b1, mk(7'h7F, 3'b100, 5'd9, 7'h5B), 32'hAAAA, 32'hBBBB, 1'b0);
        cycle("full_hold");
        cycle("full_hold");
        bus.issue_ready_i = 1'b1;
        cycle("full_pop");
        bus.issue_ready_i = 1'b0;
        cycle("fifth_accept");
        idle(6, 1'b1, "fill_drain");

        // Illegal: unknown opcode, custom-2 funct3 111
        drive(1'b1, mk(7'h0, 3'b000, 5'd1, 7'h33), '0, '0, 1'b0); cycle("ill_opc");
        idle(1, 1'b0, "ill_opc_pulse");
        drive(1'b1, mk(7'h0, 3'b111, 5'd1, 7'h5B), '0, '0, 1'b0); cycle("ill_f3");
        idle(1, 1'b0, "ill_f3_pulse");

        // FLUSH with a concurrent head issue
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(7'h1, 3'(i), 5'(i + 10), 7'h0B), 32'($urandom), 32'($urandom), 1'b0);
            cycle("flush_fill");
        end
        drive(1'b1, I_FLUSH, '0, '0, 1'b1);               cycle("flush");
        idle(2, 1'b1, "flush_after");

        // DISABLE with two queued entries
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, mk(7'h2, 3'b001, 5'(i + 20), 7'h2B), 32'($urandom), 32'($urandom), 1'b0);
            cycle("dis_fill");
        end
        drive(1'b1, I_DISABLE, '0, '0, 1'b1);             cycle("disable");
        idle(3, 1'b1, "drain");
        drive(1'b1, mk(7'h0, 3'b000, 5'd3, 7'h0B), 32'h1, 32'h2, 1'b1); cycle("ill_disabled");
        idle(1, 1'b1, "ill_disabled_pulse");

        // DISABLE with an empty queue: one drain cycle
        drive(1'b1, I_DISABLE, '0, '0, 1'b1);             cycle("disable_empty");
        idle(2, 1'b1, "disable_empty_after");

        // Async reset with three entries queued
        drive(1'b1, I_ENABLE, '0, '0, 1'b0);              cycle("rst_en");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(7'h3, 3'b000, 5'(i), 7'h7B), 32'($urandom), 32'($urandom), 1'b0);
            cycle("rst_fill");
        end
        async_reset("async_rst");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_instr(), 32'($urandom), 32'($urandom),
                  1'($urandom_range(0, 2) != 0));
            cycle("rand");
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
